// File: rtl/oam_unit.sv
// OAM responder: 160-byte sprite table, FF46 DMA launch register,
// gated CPU window and a ready/valid sprite-scan stream to the PPU.
module oam_unit #(
  parameter int OAM_BYTES    = 160,
  parameter int SCAN_ENTRIES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Di_cpu,
  output logic [7:0]  Do_cpu,
  input  logic        wr_cpu,
  input  logic        rd_cpu,
  input  logic [1:0]  ppu_mode,
  output logic [7:0]  dmaAdress,
  input  logic        DmaEnableSignal,
  input  logic [15:0] A_dma,
  input  logic [7:0]  Di_dma,
  input  logic        wr_dma,
  input  logic        rd_dma,
  output logic [7:0]  Do_dma,
  input  logic        scan_start,
  output logic        scan_busy,
  output logic        scan_valid,
  input  logic        scan_ready,
  output logic [5:0]  scan_index,
  output logic [7:0]  scan_y,
  output logic [7:0]  scan_x,
  output logic [7:0]  scan_tile,
  output logic [7:0]  scan_attr,
  output logic        scan_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT
  } state_t;

  localparam logic [7:0] LIMIT = 8'(OAM_BYTES);
  localparam logic [5:0] LAST  = 6'(SCAN_ENTRIES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] mem [OAM_BYTES];
  logic [5:0] idx;
  logic [1:0] bsel;
  logic [7:0] scan_addr;
  logic [7:0] dma_reg;
  logic       launch;

  logic dma_hit;
  logic fetch_go;
  logic oam_win;
  logic hi_win;
  logic ff46;
  logic locked;
  logic cpu_wr;
  logic accept;
  logic last_fetch;
  logic unused_dma_hi;

  assign unused_dma_hi = ^A_dma[15:8];

  assign scan_addr  = {idx, bsel};
  assign dma_hit    = wr_dma && (A_dma[7:0] < LIMIT);
  // Any DMA write owns the port, so the fetch stalls that cycle.
  assign fetch_go   = (state == S_FETCH) && !wr_dma;
  assign oam_win    = (A_cpu[15:8] == 8'hFE) && (A_cpu[7:0] < LIMIT);
  assign hi_win     = (A_cpu[15:8] == 8'hFE) && !(A_cpu[7:0] < LIMIT);
  assign ff46       = (A_cpu == 16'hFF46);
  assign locked     = DmaEnableSignal || ppu_mode[1] || fetch_go;
  assign cpu_wr     = wr_cpu && oam_win && !locked && !wr_dma;
  assign accept     = (state == S_PRESENT) && scan_ready;
  assign last_fetch = fetch_go && (bsel == 2'd3);

  always_ff @(posedge clock) begin
    if (dma_hit)
      mem[A_dma[7:0]] <= Di_dma;
    else if (cpu_wr)
      mem[A_cpu[7:0]] <= Di_cpu;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (scan_start)
          state_nxt = S_FETCH;
      S_FETCH:
        if (last_fetch)
          state_nxt = S_PRESENT;
      S_PRESENT:
        if (accept)
          state_nxt = (idx == LAST) ? S_IDLE : S_FETCH;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    scan_valid = (state == S_PRESENT);
    scan_busy  = (state != S_IDLE);
  end

  assign scan_index = idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      bsel      <= '0;
      scan_y    <= '0;
      scan_x    <= '0;
      scan_tile <= '0;
      scan_attr <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= accept && (idx == LAST);
      if (state == S_IDLE && scan_start) begin
        idx  <= '0;
        bsel <= '0;
      end
      if (fetch_go) begin
        bsel <= bsel + 2'd1;
        unique case (bsel)
          2'd0: scan_y    <= mem[scan_addr];
          2'd1: scan_x    <= mem[scan_addr];
          2'd2: scan_tile <= mem[scan_addr];
          2'd3: scan_attr <= mem[scan_addr];
          default: ;
        endcase
      end
      if (accept && idx != LAST)
        idx <= idx + 6'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Do_cpu    <= '0;
      Do_dma    <= '0;
      dma_reg   <= '0;
      launch    <= 1'b0;
      dmaAdress <= '0;
    end else begin
      if (rd_cpu) begin
        unique case (1'b1)
          oam_win: Do_cpu <= locked ? 8'hFF : mem[A_cpu[7:0]];
          hi_win:  Do_cpu <= 8'h00;
          ff46:    Do_cpu <= dma_reg;
          default: Do_cpu <= 8'hFF;
        endcase
      end
      if (rd_dma)
        Do_dma <= (A_dma[7:0] < LIMIT) ? mem[A_dma[7:0]] : 8'hFF;
      if (wr_cpu && ff46)
        dma_reg <= Di_cpu;
      // Pulse one cycle after the register write; zero never launches.
      launch    <= wr_cpu && ff46 && (Di_cpu != 8'h00);
      dmaAdress <= launch ? dma_reg : 8'h00;
    end
  end

endmodule

// File: doc/oam_unit.md
# oam_unit

Object Attribute Memory responder: owns the 160-byte sprite table at FE00-FE9F and the DMA source register FF46. It is the target end of the OAM DMA engine: it launches transfers by pulsing `dmaAdress` and absorbs the engine's byte writes. It also serves gated CPU accesses and streams sprite entries to the PPU through a ready/valid sprite-scan port. Sits between the CPU bus decode, the DMA engine's OAM-side port and the PPU.

## Interface
- `OAM_BYTES`, 160: table size in bytes (40 entries × 4 bytes).
- `SCAN_ENTRIES`, 40: entries emitted per scan.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `A_cpu` in 16: CPU address.
- `Di_cpu` in 8: CPU write data.
- `Do_cpu` out 8: CPU read data, registered.
- `wr_cpu`, `rd_cpu` in 1: CPU strobes, one cycle per access.
- `ppu_mode` in 2: current PPU mode; modes 2 and 3 lock CPU access to OAM.
- `dmaAdress` out 8: one-cycle launch pulse carrying the source page; 00 when idle.
- `DmaEnableSignal` in 1: DMA engine busy.
- `A_dma` in 16, `Di_dma` in 8, `wr_dma` in 1: DMA engine writes (byte index in `A_dma[7:0]`).
- `rd_dma` in 1, `Do_dma` out 8: DMA-side readback, registered.
- `scan_start` in 1: begin a sprite scan.
- `scan_busy` out 1: scan in progress.
- `scan_valid` out 1, `scan_ready` in 1: entry handshake.
- `scan_index` out 6: entry number, 0..39.
- `scan_y`, `scan_x`, `scan_tile`, `scan_attr` out 8 each: bytes 0..3 of the entry.
- `scan_done` out 1: one-cycle pulse after the last entry is accepted.

## Operation
- **Storage.** Single-port 160×8 array, one access per cycle. The array is not cleared by reset.
- **Arbitration.** DMA write has priority over scan fetch, which has priority over CPU access.
- **DMA writes.** Write `Di_dma` to index `A_dma[7:0]`. Indices ≥160 are ignored.
- **CPU OAM window (FE00-FE9F).**
  - Reads return the byte, or FF when `DmaEnableSignal`=1, `ppu_mode`≥2, or a scan fetch owns the port that cycle.
  - Writes under the same conditions are dropped.
  - FEA0-FEFF reads return 00; writes are ignored.
- **FF46.**
  - A CPU write stores the value in `dma_reg`; FF46 reads return `dma_reg`.
  - In the next cycle `dmaAdress`=value for exactly one cycle, then 00.
  - Writing 00 launches nothing.
  - A write while `DmaEnableSignal`=1 still pulses, which restarts the engine.
- **Scan FSM: IDLE → FETCH → PRESENT.**
  - IDLE: `scan_start`=1 → FETCH with index 0, byte 0. `scan_start` is ignored outside IDLE.
  - FETCH: read byte `index*4+b` into the matching output register, b=0..3. The byte counter holds for any cycle in which `wr_dma` takes the port (stall). After b=3 → PRESENT.
  - PRESENT: `scan_valid`=1, and outputs are held stable until `scan_ready`=1.
  - On accept with index<39: index+1 → FETCH.
  - On accept with index=39: pulse `scan_done` → IDLE.
  - `scan_busy`=1 in FETCH and PRESENT.
- **Index arithmetic.** 6-bit index; byte address = {index, b} computed as index*4+b, 8 bits, maximum 159.

## Timing
- **Reset values:** `Do_cpu`=00, `Do_dma`=00, `dmaAdress`=00, `dma_reg`=00, FSM IDLE, `scan_valid`=0, `scan_busy`=0, `scan_done`=0, `scan_index`=0, `scan_y`/`scan_x`/`scan_tile`/`scan_attr`=00.
- **Reset mid-operation:** reset asserted mid-scan or mid-pulse returns the block to the reset values immediately, asynchronously.
- **CPU and DMA read latency:** data is valid in the cycle after the `rd_cpu`/`rd_dma` edge.
- **FF46 launch:** `dmaAdress` pulse goes high at the edge after the `wr_cpu` edge.
- **Scan timing, no stalls:** `scan_start` sampled at edge N; fetch edges N+1..N+4; `scan_valid` high after edge N+4.
- **Entry pacing:** 5 cycles per entry with `scan_ready` tied high; a full scan takes 200 cycles. Each DMA write during FETCH adds one cycle.
- **`scan_done`:** high for the cycle after the accepting edge of entry 39.
- **Simultaneous events:**
  - `wr_dma` and a CPU write in the same cycle: the DMA write lands and the CPU write is dropped.
  - `scan_start` on the same edge as `scan_done` entering IDLE is ignored.

## Test plan
- **FF46 launch:** CPU writes C1 to FF46 → `dmaAdress`=C1 for exactly 1 cycle, then 00; an FF46 read returns C1. Writing 00 → no pulse.
- **DMA fill and scan:** DMA writes value i to index i, for i=0..159. Read back via `rd_dma` → index 37 returns 37; `A_dma` low byte A0 with `wr_dma` → no change anywhere. Start a scan with `scan_ready`=1 → entry 5 shows y=14, x=15, tile=16, attr=17; `scan_done` fires 200 cycles after start.
- **CPU locking:** with `ppu_mode`=3, CPU write 55 to FE10 and read FE10 → read returns FF, and a later unlocked read returns the old value. With `ppu_mode`=0 and DMA idle → the write sticks and the read returns 55.
- **Backpressure and stalls:** hold `scan_ready`=0 for 10 cycles at entry 2 → outputs stable and `scan_valid` held. Inject a `wr_dma` during FETCH → entry completes 1 cycle later with correct bytes.
- **Reset mid-operation:** assert `reset` during entry 20 FETCH → `scan_busy`=0 and `scan_valid`=0 immediately. A new `scan_start` restarts at `scan_index` 0.
